seq_grader: RTL and testbench



---
 rtl/seq_grader_if.sv | 23 ++
 rtl/seq_grader.sv | 142 ++++++++++++++
 tb/tb_seq_grader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_grader_if.sv
// seq_grader_if: sample input and status output bundle for seq_grader.
// master drives in_valid/in_pass; slave (the grader) drives the status side.
interface seq_grader_if;
  logic       in_valid;
  logic       in_pass;
  logic [1:0] status;
  logic       verdict_pulse;
  logic [3:0] pass_count;
  logic [7:0] approve_cnt;
  logic [7:0] reject_cnt;

  modport master (
    output in_valid, in_pass,
    input  status, verdict_pulse, pass_count,
    input  approve_cnt, reject_cnt
  );

  modport slave (
    input  in_valid, in_pass,
    output status, verdict_pulse, pass_count,
    output approve_cnt, reject_cnt
  );
endinterface

// File: rtl/seq_grader.sv
// seq_grader: grades a run of up to N_STEPS pass/fail samples into an
// approve/reject verdict held HOLD_CYC cycles; rejects early once approval
// is impossible, aborts the run when in_valid drops mid-run.
// Ports: clk, rst (async, active-high), bus (seq_grader_if.slave):
//   in_valid/in_pass in; status, verdict_pulse, pass_count,
//   approve_cnt, reject_cnt out.
// Macro STATS_EN: when defined, approve_cnt/reject_cnt count verdicts
// (saturating at 255); when undefined both read 0.
module seq_grader #(
  parameter int N_STEPS  = 4,
  parameter int PASS_MIN = 3,
  parameter int HOLD_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  seq_grader_if.slave bus
);

  // State encoding doubles as the status code.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    EVAL    = 2'b01,
    REJECT  = 2'b10,
    APPROVE = 2'b11
  } state_t;

  localparam logic [3:0] STEPS_LAST = 4'(N_STEPS);
  localparam logic [3:0] FAIL_MAX   = 4'(N_STEPS - PASS_MIN);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);

  state_t     state_q, state_d;
  logic [3:0] step_q, step_d;
  logic [3:0] pass_q, pass_d;
  logic [3:0] fail_q, fail_d;
  logic [7:0] hold_q, hold_d;
  logic [1:0] status_q, status_d;
  logic       pulse_q, pulse_d;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE, EVAL: begin
        if (bus.in_valid) begin
          // IDLE counters are zero, so this also starts a run at step 1.
          step_d = step_q + 4'd1;
          if (bus.in_pass) pass_d = pass_q + 4'd1;
          else             fail_d = fail_q + 4'd1;
          hold_d = '0;
          if (fail_d > FAIL_MAX)
            state_d = REJECT;
          else if (step_d == STEPS_LAST)
            state_d = APPROVE;
          else
            state_d = EVAL;
        end else begin
          state_d = IDLE;
          step_d  = '0;
          pass_d  = '0;
          fail_d  = '0;
        end
      end
      REJECT, APPROVE: begin
        if (hold_q == HOLD_LAST) begin
          state_d = IDLE;
          step_d  = '0;
          pass_d  = '0;
          fail_d  = '0;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    status_d = state_q;
    // First verdict cycle is the one with the hold counter still at zero.
    pulse_d  = state_q[1] && (hold_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      step_q   <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      hold_q   <= '0;
      status_q <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      hold_q   <= hold_d;
      status_q <= status_d;
      pulse_q  <= pulse_d;
    end
  end

`ifdef STATS_EN
  logic [7:0] app_q, app_d;
  logic [7:0] rej_q, rej_d;
  logic       ent_app, ent_rej;

  always_comb begin
    ent_app = (state_d == APPROVE) && (state_q != APPROVE);
    ent_rej = (state_d == REJECT) && (state_q != REJECT);
    app_d   = app_q;
    rej_d   = rej_q;
    if (ent_app && app_q != 8'hFF) app_d = app_q + 8'd1;
    if (ent_rej && rej_q != 8'hFF) rej_d = rej_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      app_q <= '0;
      rej_q <= '0;
    end else begin
      app_q <= app_d;
      rej_q <= rej_d;
    end
  end

  assign bus.approve_cnt = app_q;
  assign bus.reject_cnt  = rej_q;
`else
  assign bus.approve_cnt = '0;
  assign bus.reject_cnt  = '0;
`endif

  assign bus.status        = status_q;
  assign bus.verdict_pulse = pulse_q;
  assign bus.pass_count    = pass_q;

endmodule

// File: tb/tb_seq_grader.sv
// tb_seq_grader: random and directed stimulus for seq_grader, checked every
// cycle against a run/verdict-window model plus literal expectations.
module tb_seq_grader;
  localparam int N = 4;
  localparam int P = 3;
  localparam int H = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_grader_if bif();

  seq_grader #(
    .N_STEPS (N),
    .PASS_MIN(P),
    .HOLD_CYC(H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a run accumulates samples; a verdict opens a window of H edges
  // after the deciding edge v_start, during which inputs are ignored.
  int cyc = 0;
  int v_start = -1000;
  bit v_app = 0;
  bit active = 0;
  int m_pass = 0, m_fail = 0, m_steps = 0;
  int m_app = 0, m_rej = 0;
  int k;
  int es;
  int ep;
  int ea, er;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      v_start = -1000;
      active = 0;
      m_pass = 0; m_fail = 0; m_steps = 0;
      m_app = 0; m_rej = 0;
    end else begin
      k = cyc;
      if (k >= v_start + 1 && k <= v_start + H) es = v_app ? 3 : 2;
      else es = active ? 1 : 0;
      ep = (k == v_start + 1) ? 1 : 0;
      if (k > v_start && k <= v_start + H) begin
        if (k == v_start + H) begin
          m_pass = 0; m_fail = 0; m_steps = 0;
        end
      end else if (bif.in_valid) begin
        m_steps++;
        if (bif.in_pass) m_pass++;
        else m_fail++;
        if (m_fail > N - P) begin
          v_start = k; v_app = 0; active = 0;
          if (m_rej < 255) m_rej++;
        end else if (m_steps == N) begin
          v_start = k; v_app = 1; active = 0;
          if (m_app < 255) m_app++;
        end else begin
          active = 1;
        end
      end else begin
        active = 0;
        m_pass = 0; m_fail = 0; m_steps = 0;
      end
`ifdef STATS_EN
      ea = m_app; er = m_rej;
`else
      ea = 0; er = 0;
`endif
      #1;
      chk("status", 32'(bif.status), es);
      chk("verdict_pulse", 32'(bif.verdict_pulse), ep);
      chk("pass_count", 32'(bif.pass_count), m_pass);
      chk("approve_cnt", 32'(bif.approve_cnt), ea);
      chk("reject_cnt", 32'(bif.reject_cnt), er);
    end
  end

  task automatic drv(bit v, bit p);
    @(negedge clk);
    bif.in_valid = v;
    bif.in_pass  = p;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bif.in_valid = 1'b0;
    bif.in_pass  = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_pass();
    repeat (N) drv(1, 1);
    repeat (H) drv(0, 0);
  endtask

  int pc;
  int exp_a, exp_r;

  initial begin
    bif.in_valid = 1'b0;
    bif.in_pass  = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_status", 32'(bif.status), 0);
    chk("rst_pulse", 32'(bif.verdict_pulse), 0);
    chk("rst_pass", 32'(bif.pass_count), 0);
    chk("rst_app", 32'(bif.approve_cnt), 0);
    chk("rst_rej", 32'(bif.reject_cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-run
    drv(1, 1);
    drv(1, 1);
    chk("mid_status", 32'(bif.status), 1);
    chk("mid_pass", 32'(bif.pass_count), 2);
    @(negedge clk);
    bif.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_async_status", 32'(bif.status), 0);
    chk("rst_async_pass", 32'(bif.pass_count), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pc = 0;
    repeat (4) begin
      drv(0, 0);
      pc += int'(bif.verdict_pulse);
    end
    chk("rst_no_pulse", pc, 0);

    // All-pass run
    repeat (4) drv(1, 1);
    chk("ap_pass4", 32'(bif.pass_count), 4);
    chk("ap_status_run", 32'(bif.status), 1);
    drv(0, 0);
    chk("ap_status11a", 32'(bif.status), 3);
    chk("ap_pulse", 32'(bif.verdict_pulse), 1);
    chk("ap_hold_pass", 32'(bif.pass_count), 4);
    drv(0, 0);
    chk("ap_status11b", 32'(bif.status), 3);
    chk("ap_pulse_off", 32'(bif.verdict_pulse), 0);
    drv(0, 0);
    chk("ap_status00", 32'(bif.status), 0);

    // Early reject; samples during hold ignored
    drv(1, 0);
    drv(1, 0);
    chk("er_status_run", 32'(bif.status), 1);
    drv(1, 1);
    chk("er_status10", 32'(bif.status), 2);
    chk("er_pulse", 32'(bif.verdict_pulse), 1);
    chk("er_hold_pass", 32'(bif.pass_count), 0);
    drv(1, 1);
    chk("er_status10b", 32'(bif.status), 2);
    drv(0, 0);
    chk("er_status00", 32'(bif.status), 0);
    chk("er_ignored", 32'(bif.pass_count), 0);

    // Threshold approve, late reject
    drv(1, 1); drv(1, 0); drv(1, 1); drv(1, 1);
    drv(0, 0);
    chk("th_app", 32'(bif.status), 3);
    drv(0, 0);
    drv(1, 1); drv(1, 1); drv(1, 0); drv(1, 0);
    drv(0, 0);
    chk("th_rej", 32'(bif.status), 2);
    chk("th_rej_pass", 32'(bif.pass_count), 2);
    drv(0, 0);

    // Abort
    drv(1, 1);
    drv(1, 1);
    drv(0, 0);
    chk("ab_pass0", 32'(bif.pass_count), 0);
    pc = int'(bif.verdict_pulse);
    drv(0, 0);
    chk("ab_status00", 32'(bif.status), 0);
    pc += int'(bif.verdict_pulse);
    chk("ab_no_pulse", pc, 0);
    drv(1, 1);
    chk("ab_clean", 32'(bif.pass_count), 1);
    drv(0, 0);

    // Random
    for (int i = 0; i < 3000; i++)
      drv($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7);

    // Statistics
    do_reset();
    repeat (3) run_pass();
    drv(1, 0); drv(1, 0);
    repeat (H) drv(0, 0);
`ifdef STATS_EN
    exp_a = 3; exp_r = 1;
`else
    exp_a = 0; exp_r = 0;
`endif
    chk("st_app3", 32'(bif.approve_cnt), exp_a);
    chk("st_rej1", 32'(bif.reject_cnt), exp_r);
    repeat (260) run_pass();
`ifdef STATS_EN
    exp_a = 255;
`endif
    chk("st_app_sat", 32'(bif.approve_cnt), exp_a);
    chk("st_rej_keep", 32'(bif.reject_cnt), exp_r);

    drv(0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
